// File: rtl/group_drain_if.sv
// Stream-side bundle of group_drain: lane results plus a capture strobe in,
// and a drained, rounded beat stream out with status flags.
interface group_drain_if #(
    parameter int GROUP_NB  = 4,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int OUT_WIDTH = 16
);
    localparam int RES_W  = IMG_WIDTH + KER_WIDTH + 1;
    localparam int LANE_W = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 1;

    logic [GROUP_NB*RES_W-1:0] result;
    logic                      last;
    logic                      busy;
    logic                      overrun;
    logic [OUT_WIDTH-1:0]      out_data;
    logic [LANE_W-1:0]         out_lane;
    logic                      out_val;
    logic                      out_rdy;

    // Producer/consumer side (drives results and ready, observes the stream)
    modport master (
        output result, last, out_rdy,
        input  busy, overrun, out_data, out_lane, out_val
    );

    // Drain block side
    modport slave (
        input  result, last, out_rdy,
        output busy, overrun, out_data, out_lane, out_val
    );
endinterface

// File: rtl/group_drain.sv
// group_drain: snapshots the group accumulator lanes on a final-result strobe
// and drains them one lane per beat, rounded half-up, arithmetically shifted
// and saturated to OUT_WIDTH. All stream outputs come straight from flops.
module group_drain #(
    parameter int GROUP_NB  = 4,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8
) (
    input  logic         clk,
    input  logic         rst,
    group_drain_if.slave bus
);
    localparam int RES_W  = IMG_WIDTH + KER_WIDTH + 1;
    localparam int EXT_W  = RES_W + 1;
    localparam int LANE_W = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE_C = LANE_W'(GROUP_NB - 1);
    localparam logic [LANE_W-1:0] LANE_ZERO_C = LANE_W'(0);
    localparam logic [LANE_W-1:0] LANE_ONE_C  = LANE_W'(1);

    // Half-LSB of the shifted result, added before the shift to round up.
    localparam logic signed [EXT_W-1:0] ROUND_C =
        (SHIFT > 0) ? $signed(EXT_W'(64'd1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)))
                    : $signed(EXT_W'(64'd0));
    localparam logic signed [EXT_W-1:0] SAT_MAX_C =
        $signed(EXT_W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1));
    // Bitwise complement of 2^(N-1)-1 is -2^(N-1).
    localparam logic signed [EXT_W-1:0] SAT_MIN_C = ~SAT_MAX_C;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [RES_W-1:0]     shadow_r [GROUP_NB];
    logic [LANE_W-1:0]    lane_r;
    logic [LANE_W-1:0]    lane_next_s;
    logic                 xfer_s;
    logic                 final_xfer_s;
    logic                 capture_s;
    logic                 drop_s;
    logic                 val_next_s;
    logic [RES_W-1:0]     sel_next_s;
    logic [OUT_WIDTH-1:0] data_next_s;
    logic [OUT_WIDTH-1:0] out_data_r;
    logic [LANE_W-1:0]    out_lane_r;
    logic                 out_val_r;
    logic                 busy_r;
    logic                 overrun_r;

    // Round half up, arithmetic shift, then clamp to the signed output range.
    function automatic logic [OUT_WIDTH-1:0] round_sat(input logic [RES_W-1:0] v);
        logic signed [EXT_W-1:0] t;
        logic [OUT_WIDTH-1:0]    r;
        t = $signed({v[RES_W-1], v}) + ROUND_C;
        t = t >>> SHIFT;
        if (t > SAT_MAX_C) begin
            r = SAT_MAX_C[OUT_WIDTH-1:0];
        end else if (t < SAT_MIN_C) begin
            r = SAT_MIN_C[OUT_WIDTH-1:0];
        end else begin
            r = t[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    // Handshake qualifiers: a beat moves while draining and the consumer is ready.
    always_comb begin
        xfer_s       = (state_r == ST_DRAIN) && bus.out_rdy;
        final_xfer_s = xfer_s && (lane_r == LAST_LANE_C);
        capture_s    = bus.last && ((state_r == ST_IDLE) || final_xfer_s);
        drop_s       = bus.last && (state_r == ST_DRAIN) && !final_xfer_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and next-lane selection.
    always_comb begin
        state_next_s = state_r;
        lane_next_s  = lane_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.last) begin
                    state_next_s = ST_DRAIN;
                    lane_next_s  = LANE_ZERO_C;
                end else begin
                    state_next_s = ST_IDLE;
                    lane_next_s  = lane_r;
                end
            end
            ST_DRAIN: begin
                if (capture_s) begin
                    // New group arrives on the final beat: restart without a bubble.
                    state_next_s = ST_DRAIN;
                    lane_next_s  = LANE_ZERO_C;
                end else if (final_xfer_s) begin
                    state_next_s = ST_IDLE;
                    lane_next_s  = LANE_ZERO_C;
                end else if (xfer_s) begin
                    state_next_s = ST_DRAIN;
                    lane_next_s  = lane_r + LANE_ONE_C;
                end else begin
                    state_next_s = ST_DRAIN;
                    lane_next_s  = lane_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                lane_next_s  = LANE_ZERO_C;
            end
        endcase
    end

    // Next output values, computed from next state so the outputs can be flopped.
    always_comb begin
        val_next_s = (state_next_s == ST_DRAIN);
        if (capture_s) begin
            sel_next_s = bus.result[0 +: RES_W];
        end else begin
            sel_next_s = shadow_r[lane_next_s];
        end
        data_next_s = round_sat(sel_next_s);
    end

    // Lane pointer and shadow snapshot of the group results.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r <= LANE_ZERO_C;
            for (int i = 0; i < GROUP_NB; i++) begin
                shadow_r[i] <= '0;
            end
        end else begin
            lane_r <= lane_next_s;
            if (capture_s) begin
                for (int i = 0; i < GROUP_NB; i++) begin
                    shadow_r[i] <= bus.result[i*RES_W +: RES_W];
                end
            end
        end
    end

    // Registered stream outputs and the sticky dropped-group flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= '0;
            out_lane_r <= LANE_ZERO_C;
            out_val_r  <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            out_data_r <= data_next_s;
            out_lane_r <= lane_next_s;
            out_val_r  <= val_next_s;
            busy_r     <= val_next_s;
            overrun_r  <= overrun_r | drop_s;
        end
    end

    assign bus.out_data = out_data_r;
    assign bus.out_lane = out_lane_r;
    assign bus.out_val  = out_val_r;
    assign bus.busy     = busy_r;
    assign bus.overrun  = overrun_r;
endmodule
